// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the hazard detection unit: FSM states, default widths
// and the bundle of pipeline control enables it drives.
package hazard_detection_unit_pkg;

    typedef enum logic [1:0] {
        HZ_IDLE   = 2'd0,
        HZ_DMISS  = 2'd1,
        HZ_DRAIN  = 2'd2,
        HZ_HALTED = 2'd3
    } hz_state_e;

    localparam int unsigned HZ_REG_W = 4;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_stall;
        logic memwb_bubble;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush/bubble control for the 5-stage pipeline: load-use, taken-branch
// flush, I/D memory miss freeze and halt drain, plus a stall-cycle counter.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned REG_W     = HZ_REG_W,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_IDEX,
    input  logic [REG_W-1:0] DstReg1_in_from_IDEX,
    input  logic [REG_W-1:0] SrcReg1_in_from_IFID,
    input  logic [REG_W-1:0] SrcReg2_in_from_IFID,
    input  logic             MemWrite_IFID,
    input  logic             Branch_taken_ID,
    input  logic             Halt_ID,
    input  logic             imem_miss,
    input  logic             dmem_miss,
    input  logic             miss_done,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             EXMEM_stall,
    output logic             MEMWB_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    hz_state_e     state_q, state_d;
    logic          ret_drain_q, ret_drain_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          halted_q, halted_d;

    hz_ctrl_t ctrl;
    logic     active;
    logic     load_use;
    logic     dmiss_stall;
    logic     stall_inc;

    // Load-use is only tracked while the pipeline is free-running; a store
    // consuming loaded data as Src2 is served by MEM-to-MEM forwarding.
    always_comb begin
        active   = (state_q == HZ_IDLE) || (state_q == HZ_DRAIN);
        load_use = active && MemRead_IDEX && (|DstReg1_in_from_IDEX) &&
                   ((DstReg1_in_from_IDEX == SrcReg1_in_from_IFID) ||
                    ((DstReg1_in_from_IDEX == SrcReg2_in_from_IFID) && !MemWrite_IFID));
        dmiss_stall = (state_q == HZ_DMISS) || (active && dmem_miss);
    end

    always_comb begin
        ctrl = '0;
        if (dmiss_stall) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.ifid_stall   = 1'b1;
            ctrl.exmem_stall  = 1'b1;
            ctrl.memwb_bubble = 1'b1;
        end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_bubble = 1'b1;
        end else if ((state_q == HZ_DRAIN) || (state_q == HZ_HALTED)) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_flush = 1'b1;
        end else if (Branch_taken_ID) begin
            ctrl.ifid_flush = 1'b1;
        end else if (imem_miss) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_flush = 1'b1;
        end
    end

    // DMISS remembers whether it was entered from DRAIN so the drain resumes
    // with its remaining count once the fill completes.
    always_comb begin
        state_d     = state_q;
        ret_drain_d = ret_drain_q;
        drain_cnt_d = drain_cnt_q;
        halted_d    = halted_q;
        case (state_q)
            HZ_IDLE: begin
                if (dmem_miss) begin
                    state_d     = HZ_DMISS;
                    ret_drain_d = 1'b0;
                end else if (Halt_ID && !load_use) begin
                    state_d     = HZ_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end
            end
            HZ_DMISS: begin
                if (miss_done) begin
                    state_d = ret_drain_q ? HZ_DRAIN : HZ_IDLE;
                end
            end
            HZ_DRAIN: begin
                if (dmem_miss) begin
                    state_d     = HZ_DMISS;
                    ret_drain_d = 1'b1;
                end else if (drain_cnt_q <= DRAIN_ONE) begin
                    state_d     = HZ_HALTED;
                    drain_cnt_d = '0;
                    halted_d    = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_ONE;
                end
            end
            HZ_HALTED: begin
                state_d = HZ_HALTED;
            end
            default: begin
                state_d = HZ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HZ_IDLE;
            ret_drain_q <= 1'b0;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign stall_inc = ctrl.pc_stall && (state_q != HZ_HALTED);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (stall_count)
    );

    assign PC_stall     = ctrl.pc_stall;
    assign IFID_stall   = ctrl.ifid_stall;
    assign IFID_flush   = ctrl.ifid_flush;
    assign IDEX_bubble  = ctrl.idex_bubble;
    assign EXMEM_stall  = ctrl.exmem_stall;
    assign MEMWB_bubble = ctrl.memwb_bubble;
    assign halted       = halted_q;

endmodule
